// File: rtl/line_buffer_loader.sv
// line_buffer_loader
// ------------------
// Fill controller for a 4-row x 16-byte line buffer. Fetches 32-bit words
// from word-addressed memory and writes them into the buffer.
//
// Every row is loaded as one shift strobe (makes room at row 0) followed by
// WORDS_PER_ROW word writes to byte indices 0, 4, 8, 12.
//
// Load modes:
//   - start    : loads ROWS rows from base_addr, stepping by row_stride.
//   - next_row : loads one row at the previous row address plus the stride.
//
// At most one memory read is outstanding. mem_rvalid is only honoured
// while waiting for the current read.
//
// All outputs are decoded from the current state and the memory response,
// so every output is 0 in IDLE and during reset.

module line_buffer_loader #(
  parameter int ROWS          = 4,
  parameter int WORDS_PER_ROW = 4,
  parameter int ADDR_W        = 16
) (
  input  logic              clk,
  input  logic              rst,          // asynchronous, active-low
  input  logic              start,
  input  logic              next_row,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] row_stride,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_rvalid,
  output logic              buf_write_en,
  output logic              buf_shift_en,
  output logic [7:0]        buf_index,
  output logic [31:0]       buf_data_in,
  output logic              busy,
  output logic              done
);

  // Counter widths: the word counter spans 0..WORDS_PER_ROW-1 and the row
  // counter spans 0..ROWS.
  localparam int WORD_W = (WORDS_PER_ROW > 1) ? $clog2(WORDS_PER_ROW) : 1;
  localparam int ROWS_W = $clog2(ROWS + 1);

  localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(WORDS_PER_ROW - 1);
  localparam logic [ROWS_W-1:0] ROWS_INIT = ROWS_W'(ROWS);
  localparam logic [ROWS_W-1:0] ONE_ROW   = ROWS_W'(1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SHIFT = 3'd1,
    REQ   = 3'd2,
    WAIT  = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] row_addr, row_addr_nxt;   // word address of the row being loaded
  logic [ADDR_W-1:0] stride, stride_nxt;       // distance between consecutive rows
  logic [WORD_W-1:0] word, word_nxt;           // word within the current row
  logic [ROWS_W-1:0] rows_left, rows_left_nxt; // rows still to load, incl. current

  // State and datapath registers; reset abandons any load in flight.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values and simulation order cannot change the result.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      row_addr  <= '0;
      stride    <= '0;
      word      <= '0;
      rows_left <= '0;
    end else begin
      state     <= state_nxt;
      row_addr  <= row_addr_nxt;
      stride    <= stride_nxt;
      word      <= word_nxt;
      rows_left <= rows_left_nxt;
    end
  end

  // Next-state logic and output decode for the load sequencer.
  // NOTE: every signal is given a default before the case statement, so no
  // path through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    state_nxt     = state;
    row_addr_nxt  = row_addr;
    stride_nxt    = stride;
    word_nxt      = word;
    rows_left_nxt = rows_left;

    mem_rd        = 1'b0;
    mem_addr      = '0;
    buf_write_en  = 1'b0;
    buf_shift_en  = 1'b0;
    buf_index     = '0;
    buf_data_in   = '0;
    done          = 1'b0;

    case (state)
      IDLE: begin
        // start wins over next_row. Either request is only seen here, so
        // requests made while busy are dropped rather than queued.
        if (start) begin
          row_addr_nxt  = base_addr;
          stride_nxt    = row_stride;
          rows_left_nxt = ROWS_INIT;
          state_nxt     = SHIFT;
        end else if (next_row) begin
          row_addr_nxt  = row_addr + stride;
          rows_left_nxt = ONE_ROW;
          state_nxt     = SHIFT;
        end
      end

      SHIFT: begin
        // Shift the buffer down one row so the new row lands at row 0.
        buf_shift_en = 1'b1;
        word_nxt     = '0;
        state_nxt    = REQ;
      end

      REQ: begin
        // One-cycle read request. The address wraps at the address width.
        mem_rd    = 1'b1;
        mem_addr  = row_addr + ADDR_W'(word);
        state_nxt = WAIT;
      end

      WAIT: begin
        // Write the returned word straight through to the buffer in the
        // cycle it arrives.
        if (mem_rvalid) begin
          buf_write_en = 1'b1;
          buf_data_in  = mem_rdata;
          buf_index    = 8'({word, 2'b00});
          if (word != LAST_WORD) begin
            word_nxt  = word + 1'b1;
            state_nxt = REQ;
          end else begin
            rows_left_nxt = rows_left - 1'b1;
            if (rows_left == ONE_ROW) begin
              state_nxt = DONE;
            end else begin
              row_addr_nxt = row_addr + stride;
              state_nxt    = SHIFT;
            end
          end
        end
      end

      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end

      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

endmodule
